// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: exhaustive-stimulus engine for N-input gate labs.
// Walks every input vector in ascending order, holds each for HOLD_CYCLES
// clocks, samples the DUT response on the last hold cycle and compares it
// against a selectable reduction function (AND/OR/XOR/NAND).
// Optional build macro: GATE_SWEEP_STOP_ON_FAIL_EN (stop at first mismatch,
// adds fail_vec output).
module gate_sweep_checker #(
  parameter int unsigned N_IN        = 3,
  parameter int unsigned HOLD_CYCLES = 20,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  output logic [N_IN-1:0]  vec_out,
  input  logic             dut_resp,
  output logic             expected,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic             busy,
  output logic             done,
  output logic             pass
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
  ,
  output logic [N_IN-1:0]  fail_vec
`endif
);

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_APPLY = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_t;

  state_t            state_q;
  op_t               op_q;
  logic [N_IN-1:0]   vec_q;
  logic [HW-1:0]     hold_q;
  logic [ERR_W-1:0]  err_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic              mismatch_q;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
  logic [N_IN-1:0]   fail_vec_q;
`endif

  logic              expected_d;
  logic              last_hold_d;
  logic              sample_bad_d;
  logic [ERR_W-1:0]  err_d;

  // Reference function of the vector currently on the DUT inputs.
  always_comb begin
    expected_d = 1'b0;
    case (op_q)
      OP_AND:  expected_d = &vec_q;
      OP_OR:   expected_d = |vec_q;
      OP_XOR:  expected_d = ^vec_q;
      OP_NAND: expected_d = ~&vec_q;
      default: expected_d = 1'b0;
    endcase
  end

  // Sample decision and saturating next error count.
  always_comb begin
    last_hold_d  = (hold_q == HW'(HOLD_CYCLES - 1));
    sample_bad_d = (state_q == S_APPLY) && last_hold_d && (dut_resp != expected_d);
    err_d        = err_q;
    if (sample_bad_d && (err_q != '1)) begin
      err_d = err_q + 1'b1;
    end
  end

  // Sweep FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_AND;
      vec_q      <= '0;
      hold_q     <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      mismatch_q <= 1'b0;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
      fail_vec_q <= '0;
`endif
    end else begin
      mismatch_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_APPLY;
            op_q    <= op_t'(op);
            vec_q   <= '0;
            hold_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
            fail_vec_q <= '0;
`endif
          end
        end
        S_APPLY: begin
          mismatch_q <= sample_bad_d;
          if (!last_hold_d) begin
            hold_q <= hold_q + 1'b1;
          end else begin
            hold_q <= '0;
            err_q  <= err_d;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
            if (sample_bad_d) begin
              state_q    <= S_DONE;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              pass_q     <= 1'b0;
              err_q      <= ERR_W'(1);
              fail_vec_q <= vec_q;
            end else
`endif
            if (&vec_q) begin
              // pass uses the post-sample count so the final vector is included
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end else begin
              vec_q <= vec_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign vec_out   = vec_q;
  assign expected  = expected_d;
  assign mismatch  = mismatch_q;
  assign err_count = err_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
  assign fail_vec  = fail_vec_q;
`endif

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker (N_IN=3, HOLD_CYCLES=4). A second instance
// with a 2-bit error counter exercises counter saturation.
module tb_gate_sweep_checker;

  localparam int N = 3;
  localparam int H = 4;
  localparam int BUDGET = 100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [N-1:0] vec_out, vec2;
  logic         dut_resp, dut_resp2;
  logic         expected, expected2;
  logic         mismatch, mismatch2;
  logic [15:0]  err_count;
  logic [1:0]   err2;
  logic         busy, done, pass, busy2, done2, pass2;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
  logic [N-1:0] fail_vec, fail_vec2;
`endif

  int checks = 0;
  int failures = 0;
  int resp_mode = 0;
  logic [1:0] model_op = 2'b00;

  always #5 clk = ~clk;

  gate_sweep_checker #(.N_IN(N), .HOLD_CYCLES(H), .ERR_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .vec_out(vec_out),
    .dut_resp(dut_resp), .expected(expected), .mismatch(mismatch),
    .err_count(err_count), .busy(busy), .done(done), .pass(pass)
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    , .fail_vec(fail_vec)
`endif
  );

  gate_sweep_checker #(.N_IN(N), .HOLD_CYCLES(H), .ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .vec_out(vec2),
    .dut_resp(dut_resp2), .expected(expected2), .mismatch(mismatch2),
    .err_count(err2), .busy(busy2), .done(done2), .pass(pass2)
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    , .fail_vec(fail_vec2)
`endif
  );

  function automatic logic ref_f(input logic [1:0] o, input logic [N-1:0] v);
    case (o)
      2'b00:   return &v;
      2'b01:   return |v;
      2'b10:   return ^v;
      default: return ~&v;
    endcase
  endfunction

  // Student-gate models: 0 correct, 1 stuck-0, 2 inverted, 3 stuck-1,
  // 4 follows bit 0, 5 high only for vector 2.
  function automatic logic resp_f(input int m, input logic [1:0] o, input logic [N-1:0] v);
    case (m)
      0:       return ref_f(o, v);
      1:       return 1'b0;
      2:       return ~ref_f(o, v);
      3:       return 1'b1;
      4:       return v[0];
      default: return (v == 3'd2);
    endcase
  endfunction

  always_comb dut_resp  = resp_f(resp_mode, model_op, vec_out);
  always_comb dut_resp2 = resp_f(resp_mode, model_op, vec2);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    int         mode;
    int         repulse;
    int         exp_err;   // full-sweep mismatch count
  } vec_t;

  typedef struct {
    int         err;
    int         sat;
    int         pass;
    int         done_n;
    int         last_v;
    int         mm_cnt;
    int         fvec;
    logic [7:0] mm_mask;
  } exp_t;

  exp_t sb[$];

  task automatic run_sweep(input logic [1:0] op_v, input int mode, input int repulse,
                           input int exp_err, input string tag);
    exp_t e, g;
    int first_bad, done_n, vec_bad, mm_bad, mm_cnt, ev, vi;
    logic mm_exp;
    e.mm_mask = '0;
    first_bad = -1;
    for (int v = 0; v < 8; v++) begin
      e.mm_mask[v] = ref_f(op_v, 3'(v)) != resp_f(mode, op_v, 3'(v));
      if (e.mm_mask[v] && first_bad < 0) first_bad = v;
    end
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    e.last_v = (first_bad >= 0) ? first_bad : 7;
    e.err    = (first_bad >= 0) ? 1 : 0;
    e.fvec   = (first_bad >= 0) ? first_bad : 0;
`else
    e.last_v = 7;
    e.err    = exp_err;
    e.fvec   = 0;
`endif
    e.mm_cnt = 0;
    for (int v = 0; v <= e.last_v; v++) if (e.mm_mask[v]) e.mm_cnt++;
    e.sat    = (e.err > 3) ? 3 : e.err;
    e.pass   = (e.err == 0) ? 1 : 0;
    e.done_n = (e.last_v + 1) * H + 1;
    sb.push_back(e);

    model_op = op_v; resp_mode = mode; op = op_v; start = 1'b1;
    done_n = -1; vec_bad = 0; mm_bad = 0; mm_cnt = 0;
    for (int n = 1; n <= BUDGET && done_n < 0; n++) begin
      @(negedge clk);
      start = (n == repulse);
      op    = (n == repulse) ? ~op_v : op_v;
      ev = (n - 1) / H;
      if (ev > e.last_v) ev = e.last_v;
      if (int'(vec_out) != ev || expected != ref_f(op_v, vec_out)) vec_bad++;
      if (busy != !done) vec_bad++;
      vi = (n - 1) / H - 1;
      mm_exp = (n > 1) && ((n - 1) % H == 0) && (vi <= e.last_v) && e.mm_mask[vi];
      if (mismatch) mm_cnt++;
      if (mismatch != mm_exp) mm_bad++;
      if (done) done_n = n;
    end
    start = 1'b0; op = op_v;
    g = sb.pop_front();
    chk({tag, "_done_cycle"}, done_n, g.done_n);
    chk({tag, "_err_count"}, int'(err_count), g.err);
    chk({tag, "_pass"}, int'(pass), g.pass);
    chk({tag, "_sat_err"}, int'(err2), g.sat);
    chk({tag, "_mm_pulses"}, mm_cnt, g.mm_cnt);
    chk({tag, "_mm_timing_errs"}, mm_bad, 0);
    chk({tag, "_vec_trace_errs"}, vec_bad, 0);
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    chk({tag, "_fail_vec"}, int'(fail_vec), g.fvec);
`endif
    @(negedge clk);
    chk({tag, "_hold_after_done"}, {29'd0, done, mismatch, busy} == 3'b100 ? int'(vec_out) : -1,
        g.last_v);
  endtask

  vec_t tbl[9];
  int   w;

  initial begin
    tbl[0] = '{2'b00, 0, 0, 0};
    tbl[1] = '{2'b00, 1, 0, 1};
    tbl[2] = '{2'b01, 2, 0, 8};
    tbl[3] = '{2'b01, 0, 0, 0};
    tbl[4] = '{2'b10, 0, 0, 0};
    tbl[5] = '{2'b11, 3, 0, 1};
    tbl[6] = '{2'b10, 1, 0, 4};
    tbl[7] = '{2'b11, 0, 13, 0};
    tbl[8] = '{2'b00, 5, 0, 2};

    #12;
    chk("reset_outputs", int'({vec_out, err_count, busy, done, pass, mismatch}), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", int'({busy, done}), 0);

    for (int i = 0; i < 9; i++) begin
      run_sweep(tbl[i].op, tbl[i].mode, tbl[i].repulse, tbl[i].exp_err, $sformatf("t%0d", i));
    end

    // Asynchronous reset in the middle of a sweep.
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    model_op = 2'b00; resp_mode = 0;
`else
    model_op = 2'b00; resp_mode = 4;
`endif
    op = 2'b00; start = 1'b1;
    @(negedge clk); start = 1'b0;
    w = 0;
    while (vec_out != 3'd5 && w < BUDGET) begin
      @(negedge clk); w++;
    end
    chk("midreset_reach_v5", (w < BUDGET) ? 1 : 0, 1);
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    chk("midreset_err_before", int'(err_count), 0);
`else
    chk("midreset_err_before", int'(err_count), 2);
`endif
    rst_n = 1'b0;
    #1;
    chk("midreset_async_clear", int'({vec_out, err_count, busy, done, pass, mismatch}), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("midreset_idle", int'({busy, done, vec_out}), 0);
    run_sweep(2'b00, 0, 0, 0, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
- Synthesisable exhaustive-stimulus engine for N-input combinational gate labs. It replaces hand-written per-vector benches with on-board hardware.
- Walks all 2^N_IN input combinations in ascending binary order and holds each for HOLD_CYCLES clocks.
- Samples the DUT's 1-bit response and compares it against a selectable reference function (AND/OR/XOR/NAND reduction).
- Counts mismatches and reports pass/fail.
- Sits between the lab board top level and the student's gate module.

Parameters:
- N_IN, 3, number of DUT inputs (1..16); sweep length 2^N_IN vectors.
- HOLD_CYCLES, 20, clocks each vector is held (>=2).
- ERR_W, 16, width of mismatch counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a sweep.
- op  input  2  reference function: 00 AND, 01 OR, 10 XOR, 11 NAND; latched on accepted start.
- vec_out  output  N_IN  stimulus driven to DUT inputs (bit 0 = LSB input).
- dut_resp  input  1  DUT output, assumed settled by the sample cycle.
- expected  output  1  reference function of current vec_out under latched op (combinational from registers).
- mismatch  output  1  one-cycle pulse on a failing sample.
- err_count  output  ERR_W  saturating mismatch count for the current or last sweep.
- busy  output  1  high while sweeping.
- done  output  1  high from sweep end until the next accepted start.
- pass  output  1  valid when done; 1 iff err_count == 0.

Behaviour:
- Reset (async, rst_n low) sets state IDLE and clears every output register: vec_out=0, err_count=0, busy=0, done=0, pass=0, mismatch=0, hold counter=0, latched op=00.
- States:
  - IDLE: waits for start.
  - APPLY: holds the vector; hold_cnt counts 0..HOLD_CYCLES-1.
  - DONE: results stable.
- Start acceptance:
  - start=1 at edge k in IDLE or DONE is accepted.
  - From edge k+1: busy=1, done=0, pass=0, vec_out=0, hold_cnt=0, err_count=0, op latched.
  - start while busy is ignored, with no effect on the sweep.
- Sampling and advance:
  - In APPLY at hold_cnt==HOLD_CYCLES-1, dut_resp is compared with expected on that edge.
  - On inequality: mismatch=1 for the next cycle only, and err_count increments, saturating at 2^ERR_W-1.
  - On the same edge, if vec_out is not all-ones: vec_out increments and hold_cnt returns to 0.
  - If vec_out is all-ones: go to DONE, busy=0, done=1, pass=(final err_count==0). The final sample's mismatch is included.
- Timing: done rises exactly 2^N_IN*HOLD_CYCLES cycles after busy rises.
- vec_out holds its last value (all-ones) in DONE.
- Reset mid-sweep aborts immediately to the reset values. No partial results are retained.
- Reference function expected: &vec_out, |vec_out, ^vec_out, ~&vec_out per latched op.

Optional Feature:
- Macro: GATE_SWEEP_STOP_ON_FAIL_EN.
- Defined:
  - The first mismatch ends the sweep on the same sampling edge: go to DONE, done=1, pass=0, err_count=1.
  - vec_out stays frozen at the failing vector for inspection.
  - Adds output fail_vec (N_IN), which captures the failing vector and is 0 otherwise.
- Undefined: the sweep always runs to completion, and fail_vec does not exist.

Test Plan (N_IN=3, HOLD_CYCLES=4 unless stated):
- Correct AND model on dut_resp, op=00, start pulse: vec_out steps 0..7 every 4 cycles; done rises 32 cycles after busy; err_count=0; pass=1; no mismatch pulses.
- DUT stuck-at-0, op=00: exactly one mismatch pulse, in the cycle after vector 7 is sampled; err_count=1; pass=0.
- Inverted OR response (dut_resp=~|vec), op=01: 8 mismatch pulses; err_count=8; pass=0. A following start with a correct response gives err_count=0 and pass=1, confirming clear-on-start.
- start re-pulsed at vector 3 during busy: sweep unaffected; done still at cycle 32; op change at the same time ignored.
- rst_n low at vector 5 with err_count=2: all outputs 0 asynchronously before the next edge; IDLE after release; a fresh start sweeps from vector 0.
- GATE_SWEEP_STOP_ON_FAIL_EN defined, DUT returning 1 only for vector 2, op=00: stop at vector 2; done=1; pass=0; err_count=1; fail_vec=3'b010; vec_out holds 2.
